// File: rtl/dvp_capture.sv
// DVP camera capture front-end: frame lock, byte pairing, RGB888 expansion.
// Optional 2:1 decimation in both axes when DVP_DOWNSCALE_EN is defined.
module dvp_capture #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int MODE     = 0,
  parameter int XW       = 10,
  parameter int YW       = 9
) (
  input  logic          p_clock,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    p_data,
  output logic [23:0]   pixel_data,
  output logic          pixel_valid,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          line_done,
  output logic          frame_done,
  output logic          frame_err,
  output logic [15:0]   frame_count,
  output logic          busy
);

  localparam logic [1:0] S_SYNC   = 2'd0;
  localparam logic [1:0] S_ARM    = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE);

  logic [1:0]    state;
  logic          vsync_q;
  logic          href_q;
  logic          phase;
  logic [7:0]    byte0;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic          line_ovf;
  logic          frame_ovf;
  logic          err_acc;

  logic          vs_rise;
  logic          vs_fall;
  logic          hr_rise;
  logic          hr_fall;
  logic          active;
  logic          cap;
  logic          eph;
  logic          x_in;
  logic          y_in;
  logic          keep_pix;
  logic          keep_line;
  logic          line_end;
  logic          line_bad;
  logic          frame_close;
  logic          err_now;
  logic [YW-1:0] y_next;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic [15:0]   word;
  logic [23:0]   rgb;

  assign vs_rise     = vsync & ~vsync_q;
  assign vs_fall     = ~vsync & vsync_q;
  assign hr_rise     = href & ~href_q;
  assign hr_fall     = ~href & href_q;
  assign active      = (state == S_ACTIVE);
  assign busy        = active;
  assign cap         = active & href;
  // A fresh line always starts on byte0, whatever phase was left over.
  assign eph         = hr_rise ? 1'b0 : phase;
  assign x_in        = (x_cnt < X_MAX);
  assign y_in        = (y_cnt < Y_MAX);
  assign line_end    = active & hr_fall;
  assign frame_close = active & vs_rise;
  assign word        = {byte0, p_data};
  assign y_next      = y_in ? y_cnt + 1'b1 : y_cnt;
  assign line_bad    = (x_cnt != X_MAX) | line_ovf | phase;

`ifdef DVP_DOWNSCALE_EN
  assign keep_pix  = ~x_cnt[0] & ~y_cnt[0];
  assign keep_line = ~y_cnt[0];
  assign out_x     = x_cnt >> 1;
  assign out_y     = y_cnt >> 1;
`else
  assign keep_pix  = 1'b1;
  assign keep_line = 1'b1;
  assign out_x     = x_cnt;
  assign out_y     = y_cnt;
`endif

  // Closing line folds into the frame verdict in the same cycle.
  assign err_now = err_acc | (line_end & line_bad) | frame_ovf
                 | (line_end & ~y_in)
                 | ((line_end ? y_next : y_cnt) != Y_MAX);

  always_comb begin
    rgb = '0;
    unique case (1'b1)
      (MODE == 0): rgb = {word[15:11], word[15:13],
                          word[10:5],  word[10:9],
                          word[4:0],   word[4:2]};
      (MODE == 1): rgb = {byte0, byte0, byte0};
      default:     rgb = {8'h00, word};
    endcase
  end

  always_ff @(posedge p_clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_SYNC;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      phase       <= 1'b0;
      byte0       <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      line_ovf    <= 1'b0;
      frame_ovf   <= 1'b0;
      err_acc     <= 1'b0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_done   <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      vsync_q     <= vsync;
      href_q      <= href;
      pixel_valid <= 1'b0;
      line_done   <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        S_SYNC: begin
          if (vsync) state <= S_ARM;
        end
        S_ARM: begin
          x_cnt     <= '0;
          y_cnt     <= '0;
          phase     <= 1'b0;
          line_ovf  <= 1'b0;
          frame_ovf <= 1'b0;
          err_acc   <= 1'b0;
          if (vs_fall && enable) state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (cap) begin
            if (!eph) begin
              byte0 <= p_data;
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (x_in) x_cnt <= x_cnt + 1'b1;
              else line_ovf <= 1'b1;
              if (x_in && y_in && keep_pix) begin
                pixel_valid <= 1'b1;
                pixel_data  <= rgb;
                pixel_x     <= out_x;
                pixel_y     <= out_y;
              end
            end
          end
          if (line_end) begin
            x_cnt    <= '0;
            phase    <= 1'b0;
            line_ovf <= 1'b0;
            y_cnt    <= y_next;
            if (line_bad) err_acc <= 1'b1;
            if (!y_in) frame_ovf <= 1'b1;
            if (y_in && keep_line) line_done <= 1'b1;
          end
          if (frame_close) begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 1'b1;
            frame_err   <= err_now;
            state       <= S_ARM;
          end
        end
        default: state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_dvp_capture.sv
// Scoreboard bench for dvp_capture: one RGB565 and one YUV422 instance
// sharing the same sensor stimulus.
module tb_dvp_capture;

  localparam int H = 4;
  localparam int V = 2;
`ifdef DVP_DOWNSCALE_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic vsync;
  logic href;
  logic [7:0] p_data;

  logic [23:0] pd0, pd1;
  logic        pv0, pv1;
  logic [9:0]  px0, px1;
  logic [8:0]  py0, py1;
  logic        ld0, ld1;
  logic        fd0, fd1;
  logic        fe0, fe1;
  logic [15:0] fc0, fc1;
  logic        bz0, bz1;

  always #5 clk = ~clk;

  dvp_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .MODE(0)) u_rgb (
    .p_clock(clk), .rst_n(rst_n), .enable(enable), .vsync(vsync),
    .href(href), .p_data(p_data), .pixel_data(pd0), .pixel_valid(pv0),
    .pixel_x(px0), .pixel_y(py0), .line_done(ld0), .frame_done(fd0),
    .frame_err(fe0), .frame_count(fc0), .busy(bz0));

  dvp_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .MODE(1)) u_yuv (
    .p_clock(clk), .rst_n(rst_n), .enable(enable), .vsync(vsync),
    .href(href), .p_data(p_data), .pixel_data(pd1), .pixel_valid(pv1),
    .pixel_x(px1), .pixel_y(py1), .line_done(ld1), .frame_done(fd1),
    .frame_err(fe1), .frame_count(fc1), .busy(bz1));

  typedef struct {
    logic [23:0] d;
    int          x;
    int          y;
  } pix_t;

  typedef struct {
    int cnt;
    bit err;
    bit ln;
  } frm_t;

  pix_t q0[$];
  pix_t q1[$];
  frm_t f0[$];
  frm_t f1[$];

  int checks = 0;
  int failures = 0;
  int exp_lines = 0;
  int lc0 = 0;
  int lc1 = 0;
  int exp_count = 0;
  bit m_active = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic extra(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: unexpected strobe, got 1 expected 0", nm);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pv0) begin
        if (q0.size() == 0) extra("rgb_pixel");
        else begin
          pix_t p;
          p = q0.pop_front();
          chk("rgb_data", 64'(pd0), 64'(p.d));
          chk("rgb_x", 64'(px0), 64'(p.x));
          chk("rgb_y", 64'(py0), 64'(p.y));
        end
      end
      if (pv1) begin
        if (q1.size() == 0) extra("yuv_pixel");
        else begin
          pix_t p;
          p = q1.pop_front();
          chk("yuv_data", 64'(pd1), 64'(p.d));
          chk("yuv_x", 64'(px1), 64'(p.x));
          chk("yuv_y", 64'(py1), 64'(p.y));
        end
      end
      if (ld0) lc0++;
      if (ld1) lc1++;
      if (fd0) begin
        if (f0.size() == 0) extra("rgb_frame_done");
        else begin
          frm_t f;
          f = f0.pop_front();
          chk("rgb_frame_count", 64'(fc0), 64'(f.cnt));
          chk("rgb_frame_err", 64'(fe0), 64'(f.err));
          chk("rgb_line_at_close", 64'(ld0), 64'(f.ln));
        end
      end
      if (fd1) begin
        if (f1.size() == 0) extra("yuv_frame_done");
        else begin
          frm_t f;
          f = f1.pop_front();
          chk("yuv_frame_count", 64'(fc1), 64'(f.cnt));
          chk("yuv_frame_err", 64'(fe1), 64'(f.err));
          chk("yuv_line_at_close", 64'(ld1), 64'(f.ln));
        end
      end
    end
  end

  // ra/rb: RGB565 expansion of pair A/B; ya/yb: grayscale of pair A/B
  task automatic send_line(input int nb,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input logic [23:0] ra, input logic [23:0] rb,
                           input logic [23:0] ya, input logic [23:0] yb,
                           input int y, input bit vs_end);
    logic [7:0] bs [4];
    bs = '{b0, b1, b2, b3};
    for (int i = 0; i < nb; i++) begin
      @(posedge clk); #1;
      href = 1'b1;
      p_data = bs[i % 4];
      if (i % 2 == 1 && m_active) begin
        int px;
        px = i / 2;
        if (px < H && y < V && (!DS || (px % 2 == 0 && y % 2 == 0))) begin
          q0.push_back('{(px % 2 == 0) ? ra : rb,
                         DS ? px / 2 : px, DS ? y / 2 : y});
          q1.push_back('{(px % 2 == 0) ? ya : yb,
                         DS ? px / 2 : px, DS ? y / 2 : y});
        end
      end
    end
    if (m_active && y < V && (!DS || y % 2 == 0)) exp_lines++;
    @(posedge clk); #1;
    href = 1'b0;
    p_data = 8'h00;
    if (vs_end) vsync = 1'b1;
    else repeat (3) @(posedge clk);
  endtask

  task automatic vs_pulse(input bit with_line, input bit err, input int ly);
    if (!with_line) begin
      @(posedge clk); #1;
      vsync = 1'b1;
    end
    if (m_active) begin
      exp_count++;
      f0.push_back('{exp_count, err,
                     with_line && ly < V && (!DS || ly % 2 == 0)});
      f1.push_back('{exp_count, err,
                     with_line && ly < V && (!DS || ly % 2 == 0)});
    end
    m_active = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vsync = 1'b0;
    m_active = enable;
    repeat (4) @(posedge clk);
  endtask

  task automatic red_line(input int y);
    send_line(8, 8'hF8, 8'h00, 8'hF8, 8'h00,
              24'hFF0000, 24'hFF0000, 24'hF8F8F8, 24'hF8F8F8, y, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b1;
    vsync = 1'b0;
    href = 1'b0;
    p_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_rgb", {pv0, pd0, px0, py0, ld0, fd0, fe0, fc0, bz0}, 64'h0);
    chk("reset_yuv", {pv1, pd1, px1, py1, ld1, fd1, fe1, fc1, bz1}, 64'h0);

    // release in the middle of a frame: the partial frame must be dropped
    @(posedge clk); #1;
    rst_n = 1'b1;
    red_line(0);
    red_line(1);
    @(negedge clk);
    chk("busy_after_partial", 64'(bz0), 64'h0);

    vs_pulse(1'b0, 1'b0, 0);
    red_line(0);
    red_line(1);
    vs_pulse(1'b0, 1'b0, 0);

    // 5-pixel line: fifth pixel suppressed and the frame flagged
    send_line(10, 8'h07, 8'hE0, 8'h07, 8'hE0,
              24'h00FF00, 24'h00FF00, 24'h070707, 24'h070707, 0, 1'b0);
    send_line(8, 8'h07, 8'hE0, 8'h07, 8'hE0,
              24'h00FF00, 24'h00FF00, 24'h070707, 24'h070707, 1, 1'b0);
    vs_pulse(1'b0, 1'b1, 0);

    send_line(8, 8'h80, 8'h10, 8'h40, 8'hF0,
              24'h840084, 24'h421C84, 24'h808080, 24'h404040, 0, 1'b0);
    send_line(8, 8'h80, 8'h10, 8'h40, 8'hF0,
              24'h840084, 24'h421C84, 24'h808080, 24'h404040, 1, 1'b0);
    enable = 1'b0;
    vs_pulse(1'b0, 1'b0, 0);

    red_line(0);
    red_line(1);
    @(negedge clk);
    chk("gated_count", 64'(fc0), 64'd3);
    chk("gated_busy", 64'(bz1), 64'h0);
    enable = 1'b1;
    vs_pulse(1'b0, 1'b0, 0);

    red_line(0);
    enable = 1'b0;
    red_line(1);
    enable = 1'b1;
    vs_pulse(1'b0, 1'b0, 0);

    // last href fall coincides with the vsync rise
    red_line(0);
    send_line(8, 8'hF8, 8'h00, 8'hF8, 8'h00,
              24'hFF0000, 24'hFF0000, 24'hF8F8F8, 24'hF8F8F8, 1, 1'b1);
    vs_pulse(1'b1, 1'b0, 1);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rgb_pix_left", 64'(q0.size()), 64'h0);
    chk("yuv_pix_left", 64'(q1.size()), 64'h0);
    chk("rgb_frm_left", 64'(f0.size()), 64'h0);
    chk("yuv_frm_left", 64'(f1.size()), 64'h0);
    chk("rgb_line_done_cnt", 64'(lc0), 64'(exp_lines));
    chk("yuv_line_done_cnt", 64'(lc1), 64'(exp_lines));
    chk("final_count", 64'(fc0), 64'd5);
    chk("final_err", 64'(fe1), 64'h0);
    chk("final_busy", 64'(bz0), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dvp_capture.md
Name: dvp_capture

Overview:
Parametrised DVP camera capture front-end for the OV76xx-class sensor interface. It sits between the sensor pins (pclk domain) and the frame buffer writer. It frame-locks on vsync/href, assembles 2-byte pixels in a selectable format, expands them to RGB888, and tags each pixel with x/y coordinates. It reports line/frame completion, geometry errors and a frame counter.

Parameters:
H_ACTIVE, 320, expected pixels per line (2 bytes each)
V_ACTIVE, 240, expected lines per frame
MODE, 0, pixel format: 0 = RGB565, 1 = YUV422 (Y Cb Y Cr) to grayscale, 2 = raw 16-bit
XW, 10, pixel_x width; must satisfy 2^XW > H_ACTIVE
YW, 9, pixel_y width; must satisfy 2^YW > V_ACTIVE

Ports:
p_clock  in  1  sensor pixel clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
enable  in  1  capture request; sampled only at frame start
vsync  in  1  high = vertical blanking
href  in  1  high = valid bytes on p_data
p_data  in  8  sensor byte
pixel_data  out  24  {R,G,B}, 8 bits each
pixel_valid  out  1  one-cycle strobe per accepted pixel
pixel_x  out  XW  column of current pixel_data
pixel_y  out  YW  row of current pixel_data
line_done  out  1  one-cycle pulse at href falling edge inside a frame
frame_done  out  1  one-cycle pulse at end of a captured frame
frame_err  out  1  geometry error on last completed frame
frame_count  out  16  completed frames, wraps at 65535 -> 0
busy  out  1  high in state ACTIVE

Behaviour:
- Reset (async assert, sync release): all outputs 0; state SYNC; byte phase 0; counters 0; registered vsync/href copies 0.
- Edges are detected against a one-cycle registered copy of vsync/href; p_data is used in the cycle it is sampled.
- FSM:
  SYNC: wait for vsync = 1, then go to ARM. Guarantees no partial frame after reset.
  ARM: on vsync falling edge, go to ACTIVE if enable = 1, else stay in ARM. Clear the line counter, x counter and error accumulator.
  ACTIVE: capture. On vsync rising edge, pulse frame_done, increment frame_count, update frame_err, go to ARM.
- enable deasserted mid-frame has no effect until the frame completes.
- Byte assembly, ACTIVE with href = 1:
  - Phase resets to 0 on href rising edge.
  - Phase 0 latches byte0. Phase 1 forms the pixel from {byte0, p_data}.
  - pixel_valid and pixel_data are registered: they appear the cycle after the phase-1 byte is sampled (latency 1).
- Format conversion, 16-bit word w:
  - MODE 0: R = {w[15:11], w[15:13]}, G = {w[10:5], w[10:9]}, B = {w[4:0], w[4:2]}.
  - MODE 1: the Y byte is byte0 of every pair; output {Y,Y,Y}.
  - MODE 2: {8'h00, w}.
- Coordinates:
  - pixel_x = index of the pixel within the line, from 0.
  - pixel_y = line index, incremented on each href falling edge.
- Bounds:
  - Pixels with x >= H_ACTIVE are suppressed (no pixel_valid); the x counter saturates at H_ACTIVE.
  - Lines with y >= V_ACTIVE are suppressed entirely; the y counter saturates at V_ACTIVE.
- Errors, accumulated over the frame:
  - a line ending with pixel count != H_ACTIVE;
  - a line ending with phase = 1 (odd byte count);
  - a line count at frame end != V_ACTIVE.
  - frame_err is written at frame_done and holds until the next frame_done.
- Simultaneous href falling edge and vsync rising edge: the line is counted first, then the frame closes in the same cycle. Both line_done and frame_done pulse.
- href activity outside ACTIVE is ignored: no line_done, no pixel_valid.

Optional Feature:
DVP_DOWNSCALE_EN.
- Defined: 2:1 decimation in both axes.
  - Only pixels with even full-resolution x on even full-resolution lines assert pixel_valid.
  - pixel_x and pixel_y report the halved coordinates.
  - line_done pulses only for even lines.
  - Error checks still use full-resolution counts against H_ACTIVE/V_ACTIVE.
- Undefined: every in-bounds pixel is emitted with full-resolution coordinates.

Test Plan:
- Setup: H_ACTIVE = 4, V_ACTIVE = 2, MODE 0, enable = 1. Stimulus: vsync 1->0, two lines of 8 bytes each, byte pairs F8,00. Expected: 8 pixel_valid pulses with pixel_data = FF0000, x = 0..3, y = 0..1; frame_done pulse; frame_count = 1; frame_err = 0.
- Mid-frame reset: reset released mid-frame with vsync = 0. Expected: no pixel_valid until vsync has gone 1 then 0; the next full frame is captured normally.
- Error frame: a line of 10 bytes (5 pixels). Expected: only 4 pixel_valid pulses for that line; frame_err = 1 after frame_done. A following clean frame clears it to 0.
- MODE 1: pairs 80,10 / 40,F0. Expected: pixel_data = 808080 then 404040.
- Enable gating: enable = 0 at vsync falling edge. Expected: no output and frame_count unchanged. Dropping enable mid-frame still completes that frame.
- DVP_DOWNSCALE_EN defined, same frame as the first test: exactly 2 pixel_valid pulses on line 0 (x = 0,1, y = 0) and none on line 1; frame_err = 0.
